// File: rtl/sipo_pkg.sv
// sipo_pkg: shared definitions for the serial-in parallel-out receiver.
//   state_t    - receiver FSM states (IDLE/RECV/HOLD)
//   DEFAULT_*  - default word width and bit-counter width
//   frame_len  - strobes per frame: WIDTH, or WIDTH+1 with trailing parity
// Optional feature macro: SIPO_PARITY_EN (adds an even-parity bit per frame).
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 4;
    localparam int unsigned DEFAULT_CNT_W = 5;

    function automatic int unsigned frame_len(input int unsigned width);
`ifdef SIPO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/sipo_receiver_if.sv
// sipo_receiver_if: link-side strobes and downstream word handshake.
//   start_c, shift_c, serial_in - serial link strobes and data bit
//   data_ready                  - downstream accepts data_out
//   data_out, data_valid        - reassembled word and its valid flag
//   busy, overrun               - frame in progress / sticky lost-frame flag
//   parity_err                  - only with SIPO_PARITY_EN
// Modports: master = link + downstream side, slave = receiver.
interface sipo_receiver_if
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
);
    logic             start_c;
    logic             shift_c;
    logic             serial_in;
    logic             data_ready;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             busy;
    logic             overrun;
`ifdef SIPO_PARITY_EN
    logic             parity_err;
`endif

    modport master (
        output start_c, shift_c, serial_in, data_ready,
`ifdef SIPO_PARITY_EN
        input  parity_err,
`endif
        input  data_out, data_valid, busy, overrun
    );

    modport slave (
        input  start_c, shift_c, serial_in, data_ready,
`ifdef SIPO_PARITY_EN
        output parity_err,
`endif
        output data_out, data_valid, busy, overrun
    );

endinterface

// File: rtl/sipo_bit_counter.sv
// sipo_bit_counter: counts sampled bits within a frame.
//   clk, rst_n - clock, async active-low reset
//   load_i     - frame start: count becomes 1
//   inc_i      - next bit: count + 1, saturating
//   done_o     - the bit sampled on this edge completes the frame
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int unsigned CNT_W     = DEFAULT_CNT_W,
    parameter int unsigned FRAME_LEN = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic inc_i,
    output logic done_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = CNT_W'(1);
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Looks at the value being stored so the parent can capture the word
    // on the same edge that samples the final bit.
    assign done_o = (load_i || inc_i) && (count_d == CNT_W'(FRAME_LEN));

endmodule

// File: rtl/sipo_receiver.sv
// sipo_receiver: rebuilds WIDTH-bit words (MSB first) from a serial link and
// presents them with a valid/ready handshake.
//   clk, rst_n - clock, async active-low reset
//   bus        - sipo_receiver_if.slave (strobes, serial_in, data_ready in;
//                data_out, data_valid, busy, overrun [, parity_err] out)
// Optional feature macro: SIPO_PARITY_EN - frame carries a trailing even
// parity bit; parity_err is registered alongside data_out.
module sipo_receiver
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sipo_receiver_if.slave       bus
);

    localparam int unsigned FRAME_LEN = frame_len(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             overrun_q, overrun_d;
`ifdef SIPO_PARITY_EN
    logic             perr_q, perr_d;
`endif

    logic accept_start;
    logic shift_ok;
    logic sample;
    logic done;

    // A start in HOLD only counts when the held word is consumed that cycle.
    assign accept_start = bus.start_c && ((state_q != HOLD) || bus.data_ready);
    assign shift_ok     = bus.shift_c && !bus.start_c && (state_q == RECV);
    assign sample       = accept_start || shift_ok;

    sipo_bit_counter #(
        .CNT_W     (CNT_W),
        .FRAME_LEN (FRAME_LEN)
    ) u_bit_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept_start),
        .inc_i  (shift_ok),
        .done_o (done)
    );

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        dout_d    = dout_q;
        overrun_d = overrun_q;
`ifdef SIPO_PARITY_EN
        perr_d    = perr_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept_start) state_d = RECV;
            end
            RECV: begin
                state_d = RECV;
            end
            HOLD: begin
                if (bus.data_ready) begin
                    state_d = accept_start ? RECV : IDLE;
                end else if (bus.start_c) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (sample) begin
`ifdef SIPO_PARITY_EN
            // The parity bit is not shifted in; the data bits are already
            // complete in sreg when it arrives.
            if (done) begin
                state_d = HOLD;
                dout_d  = sreg_q;
                perr_d  = ^{sreg_q, bus.serial_in};
            end else begin
                sreg_d = WIDTH'({sreg_q, bus.serial_in});
            end
`else
            sreg_d = WIDTH'({sreg_q, bus.serial_in});
            if (done) begin
                state_d = HOLD;
                dout_d  = WIDTH'({sreg_q, bus.serial_in});
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            dout_q    <= '0;
            overrun_q <= 1'b0;
`ifdef SIPO_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            dout_q    <= dout_d;
            overrun_q <= overrun_d;
`ifdef SIPO_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.data_valid = (state_q == HOLD);
    assign bus.busy       = (state_q == RECV);
    assign bus.overrun    = overrun_q;
`ifdef SIPO_PARITY_EN
    assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_sipo_receiver.sv
// tb_sipo_receiver: directed table-driven bench for sipo_receiver (WIDTH=4),
// plus hand-written sequences for abort, async reset and parity.
module tb_sipo_receiver;

`ifdef SIPO_PARITY_EN
    localparam int unsigned FLEN = 5;
`else
    localparam int unsigned FLEN = 4;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    sipo_receiver_if #(.WIDTH(4)) bus ();

    sipo_receiver #(
        .WIDTH (4),
        .CNT_W (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic       start;
        logic       shift;
        logic       sin;
        logic       ready;
        logic [3:0] dout;
        logic       valid;
        logic       busy;
        logic       ov;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic push(input logic st, input logic sh, input logic si, input logic rd,
                        input logic [3:0] d, input logic v, input logic b, input logic o);
        vec_t r;
        r.start = st; r.shift = sh; r.sin = si; r.ready = rd;
        r.dout = d; r.valid = v; r.busy = b; r.ov = o;
        vecs.push_back(r);
    endtask

    // One full frame for word w (plus even parity bit when enabled);
    // data_out keeps prev until the last strobe.
    task automatic push_frame(input logic [3:0] w, input logic rd,
                              input logic [3:0] prev, input logic o);
        logic bit_v;
        logic last;
        for (int i = 0; i < int'(FLEN); i++) begin
            bit_v = (i < 4) ? w[3-i] : ^w;
            last  = (i == int'(FLEN) - 1);
            push(i == 0, i != 0, bit_v, rd, last ? w : prev, last, !last, o);
        end
    endtask

    task automatic drive(input logic st, input logic sh, input logic si, input logic rd);
        bus.start_c    = st;
        bus.shift_c    = sh;
        bus.serial_in  = si;
        bus.data_ready = rd;
    endtask

    task automatic step(input logic st, input logic sh, input logic si, input logic rd);
        drive(st, sh, si, rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0);

        // Basic frame 1011, long hold with ignored shift, ready pulse.
        push_frame(4'b1011, 1'b0, 4'b0000, 1'b0);
        for (int i = 0; i < 10; i++) push(0, 0, 0, 0, 4'b1011, 1, 0, 0);
        push(0, 1, 0, 0, 4'b1011, 1, 0, 0);
        push(0, 0, 0, 1, 4'b1011, 0, 0, 0);
        push(0, 0, 0, 0, 4'b1011, 0, 0, 0);
        // Overrun: start while holding, later shifts ignored, flag sticks.
        push_frame(4'b1011, 1'b0, 4'b1011, 1'b0);
        push(1, 0, 0, 0, 4'b1011, 1, 0, 1);
        push(0, 1, 1, 0, 4'b1011, 1, 0, 1);
        push(0, 1, 1, 0, 4'b1011, 1, 0, 1);
        push(0, 0, 0, 1, 4'b1011, 0, 0, 1);
        push_frame(4'b0110, 1'b1, 4'b1011, 1'b1);
        // Ready and start together in HOLD: new frame 1001 starts at once.
        push(1, 0, 1, 1, 4'b0110, 0, 1, 1);
        push(0, 1, 0, 0, 4'b0110, 0, 1, 1);
        push(0, 1, 0, 0, 4'b0110, 0, 1, 1);
`ifdef SIPO_PARITY_EN
        push(0, 1, 1, 0, 4'b0110, 0, 1, 1);
        push(0, 1, 0, 0, 4'b1001, 1, 0, 1);
`else
        push(0, 1, 1, 0, 4'b1001, 1, 0, 1);
`endif
        push(0, 0, 0, 1, 4'b1001, 0, 0, 1);
        push(0, 1, 1, 0, 4'b1001, 0, 0, 1);

        // Reset state.
        #2;
        chk4("reset data_out", bus.data_out, 4'b0000);
        chk1("reset data_valid", bus.data_valid, 1'b0);
        chk1("reset busy", bus.busy, 1'b0);
        chk1("reset overrun", bus.overrun, 1'b0);
`ifdef SIPO_PARITY_EN
        chk1("reset parity_err", bus.parity_err, 1'b0);
`endif
        #10;
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].shift, vecs[i].sin, vecs[i].ready);
            @(posedge clk);
            #1;
            chk4($sformatf("vec%0d data_out", i), bus.data_out, vecs[i].dout);
            chk1($sformatf("vec%0d data_valid", i), bus.data_valid, vecs[i].valid);
            chk1($sformatf("vec%0d busy", i), bus.busy, vecs[i].busy);
            chk1($sformatf("vec%0d overrun", i), bus.overrun, vecs[i].ov);
        end

        // Abort: frame 1,1 restarted, then 0,0,0,1 -> 0001, no overrun.
        rst_n = 1'b0;
        #2;
        chk1("rst clears overrun", bus.overrun, 1'b0);
        rst_n = 1'b1;
        step(1, 0, 1, 0);
        step(0, 1, 1, 0);
        step(1, 0, 0, 0);
        chk1("abort busy", bus.busy, 1'b1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
`ifdef SIPO_PARITY_EN
        chk1("abort not early", bus.data_valid, 1'b0);
        step(0, 1, 1, 0);
        chk1("abort parity_err", bus.parity_err, 1'b0);
`endif
        chk1("abort data_valid", bus.data_valid, 1'b1);
        chk4("abort data_out", bus.data_out, 4'b0001);
        chk1("abort overrun", bus.overrun, 1'b0);
        chk1("abort busy done", bus.busy, 1'b0);

        // Async reset mid-frame, then a fresh frame 1100.
        step(0, 0, 0, 1);
        step(1, 0, 1, 0);
        step(0, 1, 0, 0);
        chk1("midframe busy", bus.busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #2;
        chk4("async rst data_out", bus.data_out, 4'b0000);
        chk1("async rst busy", bus.busy, 1'b0);
        chk1("async rst data_valid", bus.data_valid, 1'b0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(1, 0, 1, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
`ifdef SIPO_PARITY_EN
        step(0, 1, 0, 0);
`endif
        chk1("fresh data_valid", bus.data_valid, 1'b1);
        chk4("fresh data_out", bus.data_out, 4'b1100);
        step(0, 0, 0, 1);
        chk1("fresh consumed", bus.data_valid, 1'b0);

`ifdef SIPO_PARITY_EN
        // Parity good then bad on the same data word 1011.
        step(1, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        chk1("par ok valid", bus.data_valid, 1'b1);
        chk1("par ok parity_err", bus.parity_err, 1'b0);
        chk4("par ok data_out", bus.data_out, 4'b1011);
        step(0, 0, 0, 1);
        step(1, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        chk1("par bad valid", bus.data_valid, 1'b1);
        chk1("par bad parity_err", bus.parity_err, 1'b1);
        chk4("par bad data_out", bus.data_out, 4'b1011);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sipo_receiver.md
Name: sipo_receiver

Overview:
- Serial-in parallel-out receiver. It is the far end of the team's serial bit link, where the sender loads a word and shifts it out MSB first, one bit per shift strobe.
- Rebuilds WIDTH-bit words from the serial stream and presents each word with a valid/ready handshake.
- Sits between the serial link and downstream parallel logic such as the adder/accumulator datapath.

Parameters:
- WIDTH, 4, bits per word. Legal range 1..16.
- CNT_W, 5, width of the bit counter. Must satisfy 2^CNT_W > WIDTH+1.

Ports:
- clk  input  1  system clock. All state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start_c  input  1  frame-start strobe. serial_in is sampled as the first (MSB) bit.
- shift_c  input  1  next-bit strobe. serial_in is sampled as the next bit.
- serial_in  input  1  serial data bit from the link.
- data_ready  input  1  downstream accepts data_out.
- data_out  output  WIDTH  reassembled word. First received bit is at data_out[WIDTH-1].
- data_valid  output  1  data_out holds a complete word.
- busy  output  1  a frame is partially received.
- overrun  output  1  sticky: a frame was lost because the previous word was not yet consumed.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, shift register=0, count=0, data_out=0, data_valid=0, busy=0, overrun=0.
- States: IDLE, RECV, HOLD. Outputs are registered. busy=(state==RECV). data_valid=(state==HOLD).
- Bit order: MSB first. The shift register updates as sreg <= {sreg[WIDTH-2:0], serial_in}.
- Strobe priority: start_c beats shift_c in the same cycle.
- IDLE:
  - shift_c is ignored.
  - start_c: sample bit, count=1, go to RECV. If WIDTH==1, go straight to HOLD instead.
- RECV:
  - shift_c: sample bit, count+1.
  - When the sampled bit is bit number WIDTH: data_out is loaded with the completed word on that same edge and the state becomes HOLD. data_valid is high in the next cycle (latency = 1 clk after the final strobe).
  - start_c: abort the partial frame with no flag, sample the bit as a new MSB, count=1.
  - Neither strobe: hold state; no timeout.
- HOLD:
  - data_out is stable while data_valid=1.
  - data_ready=1 completes the transfer; data_valid drops the following cycle.
  - data_ready=1 and start_c=1 together: the transfer completes and the new frame starts (RECV, count=1) in the same cycle.
  - start_c=1 with data_ready=0: overrun is set to 1, the new frame is discarded, and the state stays HOLD. Later shift_c strobes are ignored until the next start_c after leaving HOLD.
  - shift_c alone is ignored.
- overrun is cleared only by reset.
- Counter saturates. It never wraps within a frame because completion forces HOLD.
- Reset mid-frame or mid-HOLD: all state is discarded immediately and the pending word is lost.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - A frame is WIDTH+1 strobes; the final bit is even parity over the data bits.
  - Extra output parity_err (1 bit, reset 0) is registered together with data_out. It is valid while data_valid=1.
  - data_valid rises one cycle after the parity bit is sampled.
- Undefined:
  - A frame is WIDTH strobes.
  - There is no parity_err port and no parity logic.

Decomposition:
- Package/include sipo_pkg holds:
  - state encodings IDLE=2'd0, RECV=2'd1, HOLD=2'd2;
  - the default WIDTH;
  - the frame-length constant (WIDTH, or WIDTH+1 under SIPO_PARITY_EN).
- One natural sub-module: sipo_bit_counter.
  - Inputs: clear/load-1 on start, increment on shift.
  - Output: a done flag when the count reaches the frame length.
  - Reset: async active-low, same as the parent.

Test Plan (WIDTH=4):
- Reset, start_c with serial_in=1, then shift_c x3 with bits 0,1,1, data_ready=0 → data_valid=1 one clk after the 3rd shift_c, data_out=4'b1011, busy=0.
- Hold data_ready=0 for 10 cycles, then pulse data_ready → data_out stays 1011 throughout; data_valid=0 the cycle after the ready pulse.
- In HOLD (word 1011), start_c with data_ready=0 → overrun=1 and stays 1. A later full frame 0110 with ready → data_out=0110, overrun still 1.
- Start a frame 1,1, then start_c again and send 0,0,0,1 → data_out=4'b0001 with no overrun.
- Assert rst_n=0 after 2 of 4 bits → all outputs 0 asynchronously. A fresh frame 1100 then yields 1100.
- SIPO_PARITY_EN: frame 1011 with parity 1 → parity_err=0. Same frame with parity 0 → parity_err=1 alongside data_valid.
